// File: rtl/usb_ep_in_packetizer.sv
// USB IN endpoint packetizer: streams FIFO bytes as DATA0/DATA1 packets, answers NAK when empty.
// Define USB_EP_IN_STALL_EN to add the halt_i input and STALL handshakes.
module usb_ep_in_packetizer #(
  parameter int MAX_PACKET_SIZE = 64
) (
  input  logic       clk48_i,
  input  logic       rst_i,
`ifdef USB_EP_IN_STALL_EN
  input  logic       halt_i,
`endif
  input  logic       startIn_i,
  input  logic       resetToggle_i,
  input  logic       handshakeValid_i,
  input  logic       handshakeAck_i,
  input  logic       dataAvailable_i,
  input  logic [7:0] data_i,
  output logic       popData_o,
  output logic       popTransDone_o,
  output logic       popTransSuccess_o,
  output logic       txReqSend_o,
  input  logic       txAcceptSend_i,
  output logic       txDataPID_o,
  output logic       txValid_o,
  output logic [7:0] txData_o,
  input  logic       txReady_i,
  output logic       txDone_o,
  output logic       respValid_o,
  output logic [1:0] respHandshakePID_o
);

  localparam int CW = $clog2(MAX_PACKET_SIZE + 1);
  localparam logic [CW-1:0] maxCount = CW'(MAX_PACKET_SIZE);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] REQ_SEND = 3'd1;
  localparam logic [2:0] STREAM   = 3'd2;
  localparam logic [2:0] WAIT_HS  = 3'd3;
  localparam logic [2:0] FINISH   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    stateNext;
  logic [CW-1:0] byteCount;
  logic          toggle;
  logic          ackLatched;
  logic          respValid;
  logic [1:0]    respPid;
  logic          halted;
  logic          streamEnd;
  logic          respNow;

`ifdef USB_EP_IN_STALL_EN
  assign halted = halt_i;
`else
  assign halted = 1'b0;
`endif

  // The first byte may take a while to appear, so an empty FIFO only ends the packet once a byte has gone out.
  assign streamEnd = (state == STREAM) &&
                     ((byteCount == maxCount) || (!dataAvailable_i && (byteCount != '0)));

  assign txReqSend_o        = (state == REQ_SEND);
  assign txValid_o          = (state == STREAM) && !streamEnd && dataAvailable_i;
  assign txData_o           = txValid_o ? data_i : 8'h00;
  assign popData_o          = txValid_o && txReady_i;
  assign txDone_o           = streamEnd;
  assign txDataPID_o        = toggle;
  assign popTransDone_o     = (state == FINISH);
  assign popTransSuccess_o  = (state == FINISH) && ackLatched;
  assign respValid_o        = respValid;
  assign respHandshakePID_o = respPid;

  assign respNow = (state == IDLE) && startIn_i && (halted || !dataAvailable_i);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (startIn_i && dataAvailable_i && !halted) stateNext = REQ_SEND;
      REQ_SEND: if (txAcceptSend_i) stateNext = STREAM;
      STREAM:   if (streamEnd) stateNext = WAIT_HS;
      WAIT_HS:  if (handshakeValid_i) stateNext = FINISH;
      FINISH:   stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk48_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      byteCount  <= '0;
      ackLatched <= 1'b0;
      respValid  <= 1'b0;
      respPid    <= 2'b00;
    end else begin
      state     <= stateNext;
      respValid <= respNow;
      respPid   <= respNow ? (halted ? 2'b11 : 2'b10) : 2'b00;
      if ((state == IDLE) && startIn_i) begin
        byteCount <= '0;
      end else if (popData_o) begin
        byteCount <= byteCount + CW'(1);
      end
      if ((state == WAIT_HS) && handshakeValid_i) begin
        ackLatched <= handshakeAck_i;
      end
    end
  end

  // An explicit toggle reset beats the flip from an ACK arriving in the same cycle.
  always_ff @(posedge clk48_i or posedge rst_i) begin
    if (rst_i) begin
      toggle <= 1'b0;
    end else if (resetToggle_i) begin
      toggle <= 1'b0;
    end else if ((state == WAIT_HS) && handshakeValid_i && handshakeAck_i) begin
      toggle <= ~toggle;
    end
  end

endmodule

// File: tb/tb_usb_ep_in_packetizer.sv
// Randomized self-checking bench for usb_ep_in_packetizer with a transaction-level packet model.
// Covers STALL answers when USB_EP_IN_STALL_EN is defined.
module tb_usb_ep_in_packetizer;

  localparam int MAX_PKT = 8;

  logic       clk48_i;
  logic       rst_i;
`ifdef USB_EP_IN_STALL_EN
  logic       halt_i;
`endif
  logic       startIn_i;
  logic       resetToggle_i;
  logic       handshakeValid_i;
  logic       handshakeAck_i;
  logic       dataAvailable_i;
  logic [7:0] data_i;
  logic       popData_o;
  logic       popTransDone_o;
  logic       popTransSuccess_o;
  logic       txReqSend_o;
  logic       txAcceptSend_i;
  logic       txDataPID_o;
  logic       txValid_o;
  logic [7:0] txData_o;
  logic       txReady_i;
  logic       txDone_o;
  logic       respValid_o;
  logic [1:0] respHandshakePID_o;

  usb_ep_in_packetizer #(.MAX_PACKET_SIZE(MAX_PKT)) dut (
    .clk48_i(clk48_i),
    .rst_i(rst_i),
`ifdef USB_EP_IN_STALL_EN
    .halt_i(halt_i),
`endif
    .startIn_i(startIn_i),
    .resetToggle_i(resetToggle_i),
    .handshakeValid_i(handshakeValid_i),
    .handshakeAck_i(handshakeAck_i),
    .dataAvailable_i(dataAvailable_i),
    .data_i(data_i),
    .popData_o(popData_o),
    .popTransDone_o(popTransDone_o),
    .popTransSuccess_o(popTransSuccess_o),
    .txReqSend_o(txReqSend_o),
    .txAcceptSend_i(txAcceptSend_i),
    .txDataPID_o(txDataPID_o),
    .txValid_o(txValid_o),
    .txData_o(txData_o),
    .txReady_i(txReady_i),
    .txDone_o(txDone_o),
    .respValid_o(respValid_o),
    .respHandshakePID_o(respHandshakePID_o)
  );

  initial clk48_i = 1'b0;
  always #5 clk48_i = ~clk48_i;

  int total = 0;
  int bad = 0;

  // FIFO as seen by the DUT, and the bench's own idea of what is committed.
  logic [7:0] fifoQ[$];
  int         rdPtr;
  logic [7:0] modelQ[$];
  logic       modelToggle;
  logic       modelHalt;
  int         readyMode;

  logic [7:0] gotBytes[$];
  int         gotPops, gotDone, gotResp, gotReq, gotTransDone, gotBadPop;
  logic [1:0] gotRespPid;
  logic       gotPid, gotSuccess;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic driveFifo();
    dataAvailable_i = (rdPtr < fifoQ.size());
    data_i = dataAvailable_i ? fifoQ[rdPtr] : 8'h00;
  endtask

  task automatic pushBytes(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      fifoQ.push_back(b);
      modelQ.push_back(b);
    end
    driveFifo();
  endtask

  task automatic clearCaptures();
    gotBytes.delete();
    gotPops = 0; gotDone = 0; gotResp = 0; gotReq = 0; gotTransDone = 0; gotBadPop = 0;
    gotRespPid = 2'b00; gotPid = 1'b0; gotSuccess = 1'b0;
  endtask

  // One clock: observe at the falling edge, then update FIFO and inputs just after the rising edge.
  task automatic applyStimulus();
    logic popNow, doneNow, succNow;
    @(negedge clk48_i);
    popNow  = popData_o;
    doneNow = popTransDone_o;
    succNow = popTransSuccess_o;
    if (txValid_o && txReady_i) gotBytes.push_back(txData_o);
    if (popData_o) gotPops++;
    if (popData_o !== (txValid_o && txReady_i)) gotBadPop++;
    if (txDone_o) gotDone++;
    if (respValid_o) begin gotResp++; gotRespPid = respHandshakePID_o; end
    if (txReqSend_o) begin gotReq++; gotPid = txDataPID_o; end
    if (popTransDone_o) begin gotTransDone++; gotSuccess = popTransSuccess_o; end
    @(posedge clk48_i);
    #1;
    if (popNow) rdPtr++;
    if (doneNow) begin
      if (succNow) for (int i = 0; i < rdPtr; i++) fifoQ.delete(0);
      rdPtr = 0;
    end
    startIn_i = 1'b0;
    handshakeValid_i = 1'b0;
    handshakeAck_i = 1'b0;
    resetToggle_i = 1'b0;
    txAcceptSend_i = ($urandom_range(0, 2) != 0);
    case (readyMode)
      0:       txReady_i = 1'b1;
      1:       txReady_i = ~txReady_i;
      default: txReady_i = 1'($urandom_range(0, 1));
    endcase
    driveFifo();
  endtask

  task automatic runIn(input logic ack, input logic clearTog, input int addAfter, input int addCount,
                       input int hsDelay);
    int budget;
    int expLen;
    logic expPid;
    bit added;
    bit expResp;
    logic [1:0] expRespPid;
    logic [31:0] actByte;
    clearCaptures();
    expPid = modelToggle;
    expResp = modelHalt || (modelQ.size() == 0);
    expRespPid = modelHalt ? 2'b11 : 2'b10;
    startIn_i = 1'b1;
    budget = 0;
    added = 0;
    do begin
      applyStimulus();
      budget++;
      if (!added && addCount > 0 && gotPops >= addAfter) begin
        pushBytes(addCount);
        added = 1;
      end
    end while (gotDone == 0 && gotResp == 0 && budget < 200);
    if (expResp) begin
      repeat (3) applyStimulus();
      checkOutput("respCount", 32'(gotResp), 32'd1);
      checkOutput("respPid", 32'(gotRespPid), 32'(expRespPid));
      checkOutput("respNoPop", 32'(gotPops), 32'd0);
      checkOutput("respNoReq", 32'(gotReq), 32'd0);
      checkOutput("respNoTransDone", 32'(gotTransDone), 32'd0);
      return;
    end
    checkOutput("txDoneSeen", 32'(gotDone), 32'd1);
    for (int i = 0; i < hsDelay; i++) begin
      startIn_i = 1'($urandom_range(0, 1));
      applyStimulus();
    end
    handshakeValid_i = 1'b1;
    handshakeAck_i = ack;
    resetToggle_i = clearTog;
    budget = 0;
    do begin
      applyStimulus();
      budget++;
    end while (gotTransDone == 0 && budget < 20);
    applyStimulus();
    expLen = (modelQ.size() < MAX_PKT) ? modelQ.size() : MAX_PKT;
    checkOutput("byteCount", 32'(gotBytes.size()), 32'(expLen));
    for (int i = 0; i < expLen; i++) begin
      actByte = (i < gotBytes.size()) ? 32'(gotBytes[i]) : 32'hffff_ffff;
      checkOutput($sformatf("byte%0d", i), actByte, 32'(modelQ[i]));
    end
    checkOutput("popCount", 32'(gotPops), 32'(expLen));
    checkOutput("popOnlyOnReady", 32'(gotBadPop), 32'd0);
    checkOutput("dataPid", 32'(gotPid), 32'(expPid));
    checkOutput("txDoneOnce", 32'(gotDone), 32'd1);
    checkOutput("noResp", 32'(gotResp), 32'd0);
    checkOutput("transDoneOnce", 32'(gotTransDone), 32'd1);
    checkOutput("transSuccess", 32'(gotSuccess), 32'(ack));
    if (ack) for (int i = 0; i < expLen; i++) modelQ.delete(0);
    if (clearTog) modelToggle = 1'b0;
    else if (ack) modelToggle = ~modelToggle;
  endtask

  initial begin
    rst_i = 1'b1;
`ifdef USB_EP_IN_STALL_EN
    halt_i = 1'b0;
`endif
    startIn_i = 1'b0; resetToggle_i = 1'b0; handshakeValid_i = 1'b0; handshakeAck_i = 1'b0;
    txAcceptSend_i = 1'b0; txReady_i = 1'b1;
    readyMode = 0; modelToggle = 1'b0; modelHalt = 1'b0; rdPtr = 0;
    driveFifo();
    #3;
    checkOutput("resetOutputs", 32'({popData_o, popTransDone_o, popTransSuccess_o, txReqSend_o, txValid_o,
                txData_o, txDone_o, respValid_o, respHandshakePID_o}), 32'd0);
    checkOutput("resetPid", 32'(txDataPID_o), 32'd0);
    repeat (2) @(posedge clk48_i);
    #1 rst_i = 1'b0;

    runIn(1'b1, 1'b0, 0, 0, 0);
    pushBytes(3);
    runIn(1'b1, 1'b0, 0, 0, 1);
    pushBytes(20);
    runIn(1'b1, 1'b0, 0, 0, 0);
    runIn(1'b1, 1'b0, 0, 0, 2);
    runIn(1'b0, 1'b0, 0, 0, 0);
    runIn(1'b1, 1'b0, 0, 0, 1);

    readyMode = 1;
    pushBytes(5);
    runIn(1'b1, 1'b0, 0, 0, 0);

    readyMode = 0;
    txReady_i = 1'b1;
    pushBytes(2);
    runIn(1'b1, 1'b0, 1, 3, 0);

    pushBytes(1);
    runIn(1'b1, 1'b1, 0, 0, 0);
    pushBytes(2);
    runIn(1'b1, 1'b0, 0, 0, 0);

    // Cut a packet off after two bytes with the toggle at DATA1.
    pushBytes(6);
    clearCaptures();
    startIn_i = 1'b1;
    for (int i = 0; i < 200 && gotPops < 2; i++) applyStimulus();
    checkOutput("preResetPops", 32'(gotPops), 32'd2);
    rst_i = 1'b1;
    #2;
    checkOutput("midResetOutputs", 32'({popData_o, popTransDone_o, popTransSuccess_o, txReqSend_o, txValid_o,
                txData_o, txDone_o, respValid_o, respHandshakePID_o}), 32'd0);
    checkOutput("midResetPid", 32'(txDataPID_o), 32'd0);
    fifoQ.delete();
    modelQ.delete();
    rdPtr = 0;
    modelToggle = 1'b0;
    driveFifo();
    repeat (2) @(posedge clk48_i);
    #1 rst_i = 1'b0;
    runIn(1'b1, 1'b0, 0, 0, 0);
    pushBytes(2);
    runIn(1'b1, 1'b0, 0, 0, 0);

`ifdef USB_EP_IN_STALL_EN
    pushBytes(3);
    halt_i = 1'b1;
    modelHalt = 1'b1;
    runIn(1'b1, 1'b0, 0, 0, 0);
    halt_i = 1'b0;
    modelHalt = 1'b0;
    runIn(1'b1, 1'b0, 0, 0, 0);
`endif

    for (int iter = 0; iter < 25; iter++) begin
      readyMode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0) pushBytes($urandom_range(1, 12));
      runIn(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), 0, 0, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
